// File: rtl/mult_share_sched.sv
// mult_share_sched
//   Round-robin scheduler sharing one multiplier among NUM_REQ requesters.
//   One request is granted at a time. Its operands are latched and the
//   multiplier is launched. The product is returned tagged with the
//   requester index through a back-pressured response port.
//
//   Optional feature: define MULT_SCHED_WATCHDOG_EN to enable a WAIT-state
//   watchdog. If the multiplier has not finished by the TIMEOUT-th WAIT
//   cycle, an error response is returned. Without it, rsp_error is tied to 0.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_valid      per-requester request valid
//   req_ready      one-hot accept, combinational, only in IDLE
//   req_a/req_b    packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_signed     per-requester signed flag (forwarded only)
//   mul_start      one-cycle launch pulse (mul_valid_in mirrors it)
//   mul_a/mul_b    latched operands
//   mul_signed     latched signed flag
//   mul_result     product from the multiplier
//   mul_done       completion pulse
//   mul_busy       multiplier busy
//   rsp_valid      response valid, held until rsp_ready
//   rsp_ready      response accept
//   rsp_id         served requester index
//   rsp_result     product (0 on watchdog timeout)
//   rsp_error      watchdog timeout flag
module mult_share_sched #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_signed,
    output logic                     mul_start,
    output logic                     mul_valid_in,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_signed,
    input  logic [2*WIDTH-1:0]       mul_result,
    input  logic                     mul_done,
    input  logic                     mul_busy,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     rsp_error
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;

    // Per-requester views of the flat operand buses.
    logic [NUM_REQ-1:0][WIDTH-1:0] a_arr;
    logic [NUM_REQ-1:0][WIDTH-1:0] b_arr;
    assign a_arr = req_a;
    assign b_arr = req_b;

    // Round-robin pick: the first valid requester at or after rr_ptr, wrapping.
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_w;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = IDW'(idx);
            if (!gnt_any && req_valid[idx_w]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_w;
            end
        end
    end

    logic gnt_ok;
    assign gnt_ok    = (state == IDLE) && gnt_any && !mul_busy && !rst;
    assign req_ready = gnt_ok ? (NUM_REQ'(1) << gnt_idx) : '0;

`ifdef MULT_SCHED_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wd_cnt;
`else
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            mul_start    <= 1'b0;
            mul_valid_in <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_signed   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
`ifdef MULT_SCHED_WATCHDOG_EN
            rsp_error    <= 1'b0;
            wd_cnt       <= '0;
`endif
        end else begin
            // Launch pulse is one cycle wide: it covers exactly the ISSUE state.
            mul_start    <= 1'b0;
            mul_valid_in <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_ok) begin
                        mul_a        <= a_arr[gnt_idx];
                        mul_b        <= b_arr[gnt_idx];
                        mul_signed   <= req_signed[gnt_idx];
                        rsp_id       <= gnt_idx;
                        mul_start    <= 1'b1;
                        mul_valid_in <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef MULT_SCHED_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state  <= WAIT;
                end
                WAIT: begin
                    if (mul_done) begin
                        rsp_result <= mul_result;
                        rsp_valid  <= 1'b1;
`ifdef MULT_SCHED_WATCHDOG_EN
                        rsp_error  <= 1'b0;
`endif
                        state      <= RESP;
                    end
`ifdef MULT_SCHED_WATCHDOG_EN
                    // wd_cnt==TIMEOUT-1 marks the TIMEOUT-th WAIT cycle.
                    else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_result <= '0;
                        rsp_error  <= 1'b1;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
